instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit_pkg.sv | 15 +
 rtl/instruction_fetch_unit_fetch_buffer.sv | 71 +++++++
 rtl/instruction_fetch_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN    : architectural register / address width
//   PC_INC  : byte distance between consecutive 32-bit instructions
//   fetch_state_e : fetch FSM states (IDLE, FETCH)
package instruction_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs.
//   clk, reset : clock and synchronous active-high reset (pointers/count only)
//   push_i     : write wdata_i at the tail this edge
//   pop_i      : advance the head this edge
//   flush_i    : drop all entries (takes priority over push/pop)
//   wdata_i    : entry to write
//   rdata_o    : current head entry (valid when count_o != 0)
//   count_o    : number of stored entries
// The caller guarantees no push when full without a simultaneous pop and no
// pop when empty. BUF_DEPTH must be a power of two so pointers wrap freely.
module fetch_buffer #(
  parameter int BUF_DEPTH = 2,
  parameter int DATA_W    = 64,
  localparam int PTR_W    = $clog2(BUF_DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only: never reset, entries are qualified by count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the PC through instruction memory, buffers
// fetched words with their addresses, and handles redirects.
//   clk, reset           : clock, synchronous active-high reset
//   fetch_enable         : 1 = fetching permitted
//   redirect_valid/target: single-cycle PC redirect (flushes buffer)
//   chip_select, address : instruction-memory request (address always = pc)
//   instruction          : memory read data, same cycle as the request
//   out_valid/ready      : consumer handshake on the buffer head
//   out_instruction/pc   : head instruction and the address it came from
//   misalign_error       : sticky, set by a redirect target with bits[1:0]!=0
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        chip_select,
  output logic [31:0] address,
  input  logic [31:0] instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic        misalign_error
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic             fetch, pop, head_valid, buf_full;
  logic [CNT_W-1:0] count;
  logic [2*XLEN-1:0] head_entry;

  assign head_valid = (count != '0);
  assign buf_full   = (count == DEPTH_C);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_enable)  state_d = FETCH;
      FETCH:   if (!fetch_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. A redirect or reset cycle neither fetches nor pops; a full
  // buffer may still fetch when the head leaves in the same cycle.
  always_comb begin
    pop   = head_valid && out_ready && !redirect_valid && !reset;
    fetch = 1'b0;
    if (state_q == FETCH && !redirect_valid && !reset)
      fetch = !buf_full || pop;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)  pc_d = {redirect_target[31:2], 2'b00};
    else if (fetch)      pc_d = pc_q + PC_INC;
  end

  assign misalign_d = misalign_q || (redirect_valid && (redirect_target[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH),
    .DATA_W    (2*XLEN)
  ) u_fetch_buffer (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fetch),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ({pc_q, instruction}),
    .rdata_o (head_entry),
    .count_o (count)
  );

  // Reset overrides the visible outputs combinationally so the reset cycle
  // itself already presents the post-reset interface.
  assign chip_select     = fetch;
  assign address         = reset ? RESET_PC : pc_q;
  assign out_valid       = head_valid && !reset;
  assign out_pc          = head_entry[2*XLEN-1:XLEN];
  assign out_instruction = head_entry[XLEN-1:0];
  assign misalign_error  = misalign_q;

endmodule
